fram_access_arb: RTL

- Arbitrates the single FRAM (e2prom) controller port between up to NREQ scan/config requesters; for example, the area2 scanner, a parameter loader and a diagnostic logger.
- Grants the port round-robin.
- Forwards the granted requester's command, write stream and read stream.
- Tracks each transaction to completion and times out a hung controller.
- Sits between the scan sequencers and the FRAM controller. It replaces direct single-owner wiring of the e2prom port.

---
 rtl/fram_arb_pkg.sv | 37 +++
 rtl/fram_access_arb_rr_arbiter.sv | 45 ++++
 rtl/fram_access_arb.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fram_arb_pkg.sv
// Shared types, widths and the round-robin pick helper
// for the FRAM access arbiter.
package fram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    BUSY
  } state_t;

  localparam int FRAM_AW = 17;
  localparam int LEN_W   = 16;
  localparam int DW      = 8;
  localparam int MAXREQ  = 4;

  // First set request at or after ptr, wrapping modulo n.
  function automatic logic [MAXREQ-1:0] rr_pick(
    input logic [MAXREQ-1:0] req,
    input logic [1:0]        ptr,
    input int                n
  );
    logic [MAXREQ-1:0] g;
    logic              found;
    int                idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < MAXREQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/fram_access_arb_rr_arbiter.sv
// Round-robin pick over the request vector with a
// registered pointer that advances past each winner.
module rr_arbiter
  import fram_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] pick
);

  logic [1:0]        ptr;
  logic [1:0]        nxt;
  logic [MAXREQ-1:0] req_w;
  logic [MAXREQ-1:0] pick_w;
  logic              pick_unused;

  assign req_w       = MAXREQ'(req);
  assign pick_w      = rr_pick(req_w, ptr, NREQ);
  assign pick        = pick_w[NREQ-1:0];
  assign pick_unused = ^pick_w;

  // Pointer value one past the current winner.
  always_comb begin
    nxt = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        nxt = (i + 1 == NREQ) ? 2'd0 : 2'(i + 1);
      end
    end
  end

  // Advance the pointer only when a grant is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 2'd0;
    end else if (en && |pick) begin
      ptr <= nxt;
    end
  end

endmodule

// File: rtl/fram_access_arb.sv
// Shares one FRAM controller port between NREQ requesters:
// round-robin ownership, command/stream mux, busy timeout.
module fram_access_arb
  import fram_arb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int TO_CYC = 200000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         im_req,
  output logic [NREQ-1:0]         om_gnt,
  input  logic [NREQ-1:0]         im_rden,
  input  logic [NREQ-1:0]         im_wren,
  input  logic [NREQ*FRAM_AW-1:0] im_addr,
  input  logic [NREQ*LEN_W-1:0]   im_wr_len,
  input  logic [NREQ-1:0]         im_wr_dv,
  input  logic [NREQ*DW-1:0]      im_wdata,
  output logic [NREQ-1:0]         om_rd_dv,
  output logic [DW-1:0]           om_rdata,
  output logic [NREQ-1:0]         om_done,
  output logic                    o_timeout,
  output logic                    o_e2prom_rden,
  output logic                    o_e2prom_wren,
  output logic [FRAM_AW-1:0]      om_e2prom_addr,
  output logic [LEN_W-1:0]        om_e2prom_wr_len,
  output logic                    o_e2prom_wr_dv,
  output logic [DW-1:0]           o_e2prom_wdata,
  input  logic                    i_e2prom_rd_dv,
  input  logic [DW-1:0]           im_e2prom_rdata,
  input  logic                    i_e2prom_rdy
);

  localparam int CW = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

  state_t             state;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    pick;
  logic [CW-1:0]      cnt;
  logic               seen_low;
  logic               arb_en;
  logic               own_req;
  logic               sel_rd;
  logic               sel_wr;
  logic               sel_wr_dv;
  logic [FRAM_AW-1:0] sel_addr;
  logic [LEN_W-1:0]   sel_len;
  logic [DW-1:0]      sel_wdata;

  assign arb_en    = (state == IDLE) && (|im_req) && i_e2prom_rdy;
  assign own_req   = |(im_req & gnt);
  assign sel_rd    = |(im_rden & gnt);
  assign sel_wr    = |(im_wren & gnt);
  assign sel_wr_dv = |(im_wr_dv & gnt);

  assign om_gnt   = gnt;
  assign om_rdata = im_e2prom_rdata;
  assign om_rd_dv = gnt & {NREQ{i_e2prom_rd_dv}};

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .clk (clk),
    .rst (rst),
    .req (im_req),
    .en  (arb_en),
    .pick(pick)
  );

  // Owner's command fields and write byte; zero without a grant.
  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr  = im_addr[i*FRAM_AW +: FRAM_AW];
        sel_len   = im_wr_len[i*LEN_W +: LEN_W];
        sel_wdata = im_wdata[i*DW +: DW];
      end
    end
  end

  // Ownership FSM with registered port outputs and timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      gnt              <= '0;
      cnt              <= '0;
      seen_low         <= 1'b0;
      om_done          <= '0;
      o_timeout        <= 1'b0;
      o_e2prom_rden    <= 1'b0;
      o_e2prom_wren    <= 1'b0;
      om_e2prom_addr   <= '0;
      om_e2prom_wr_len <= '0;
      o_e2prom_wr_dv   <= 1'b0;
      o_e2prom_wdata   <= '0;
    end else begin
      om_done        <= '0;
      o_timeout      <= 1'b0;
      o_e2prom_rden  <= 1'b0;
      o_e2prom_wren  <= 1'b0;
      o_e2prom_wr_dv <= 1'b0;
      o_e2prom_wdata <= '0;
      unique case (state)
        IDLE: begin
          om_e2prom_addr   <= '0;
          om_e2prom_wr_len <= '0;
          if (arb_en) begin
            gnt   <= pick;
            state <= OWN;
          end
        end
        OWN: begin
          if (!own_req) begin
            gnt   <= '0;
            state <= IDLE;
          end else if (i_e2prom_rdy && (sel_rd ^ sel_wr)) begin
            o_e2prom_rden    <= sel_rd;
            o_e2prom_wren    <= sel_wr;
            om_e2prom_addr   <= sel_addr;
            om_e2prom_wr_len <= sel_len;
            cnt              <= '0;
            seen_low         <= 1'b0;
            state            <= BUSY;
          end
        end
        BUSY: begin
          o_e2prom_wr_dv <= sel_wr_dv;
          o_e2prom_wdata <= sel_wr_dv ? sel_wdata : '0;
          cnt            <= cnt + 1'b1;
          if (!i_e2prom_rdy) begin
            seen_low <= 1'b1;
          end
          if (seen_low && i_e2prom_rdy) begin
            om_done <= gnt;
            state   <= OWN;
          end else if (cnt == TO_LAST) begin
            om_done   <= gnt;
            o_timeout <= 1'b1;
            gnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
